// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative M-extension unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            kill;
  logic [2:0]      funct3;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, kill, funct3, srca, srcb,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, funct3, srca, srcb,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: shift-add multiplier and restoring divider,
// one bit per cycle on operand magnitudes with sign correction at the final edge.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [2:0]        op;
  logic [XLEN-1:0]   opnd;     // multiplicand (mul) or divisor (div)
  logic [2*XLEN-1:0] acc;      // {partial product, multiplier} or {remainder, dividend/quotient}
  logic              neg_q;
  logic              neg_r;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   res;

  // Request decode, only meaningful while idle
  logic            is_div_in;
  logic            sign_a_in;
  logic            sign_b_in;
  logic            neg_a_in;
  logic            neg_b_in;
  logic [XLEN-1:0] abs_a_in;
  logic [XLEN-1:0] abs_b_in;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    is_div_in = bus.funct3[2];
    sign_a_in = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    sign_b_in = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                (bus.funct3 == 3'b110);
    neg_a_in  = sign_a_in && bus.srca[XLEN-1];
    neg_b_in  = sign_b_in && bus.srcb[XLEN-1];
    abs_a_in  = neg_a_in ? (~bus.srca + 1'b1) : bus.srca;
    abs_b_in  = neg_b_in ? (~bus.srcb + 1'b1) : bus.srcb;
    div_zero  = is_div_in && (bus.srcb == '0);
    div_ovf   = ((bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) &&
                (bus.srca == MIN_NEG) && (bus.srcb == '1);
    special_res = '0;
    if (div_zero)
      special_res = bus.funct3[1] ? bus.srca : '1;
    else if (div_ovf)
      special_res = bus.funct3[1] ? '0 : bus.srca;
  end

  // One iteration step for each datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shl;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] acc_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    div_shl  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_shl - {1'b0, opnd};
    if (div_diff[XLEN])
      div_next = {div_shl[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    acc_next = op[2] ? div_next : mul_next;
  end

  // Sign correction applied to the value the last iteration produces
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    prod_s = neg_q ? (~acc_next + 1'b1) : acc_next;
    quo_s  = neg_q ? (~acc_next[XLEN-1:0] + 1'b1) : acc_next[XLEN-1:0];
    rem_s  = neg_r ? (~acc_next[2*XLEN-1:XLEN] + 1'b1) : acc_next[2*XLEN-1:XLEN];
    case (op)
      3'b000:                 final_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo_s;
      default:                final_res = rem_s;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op    <= '0;
      opnd  <= '0;
      acc   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
      res   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.kill) begin
            op    <= bus.funct3;
            cnt   <= '0;
            neg_q <= neg_a_in ^ neg_b_in;
            neg_r <= neg_a_in;
            opnd  <= is_div_in ? abs_b_in : abs_a_in;
            acc   <= {{XLEN{1'b0}}, (is_div_in ? abs_a_in : abs_b_in)};
            if (div_zero || div_ovf) begin
              res   <= special_res;
              state <= S_DONE;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.kill) begin
            state <= S_IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              res   <= final_res;
              state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.result = res;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: 32-bit and 8-bit instances against an
// arithmetic reference model of the M-extension ops.
module tb_muldiv_unit;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) bus ();
  muldiv_unit_if #(.XLEN(8))  bus8 ();

  muldiv_unit #(.XLEN(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
  muldiv_unit #(.XLEN(8))  dut8 (.clk(clk), .reset(reset), .bus(bus8));

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  exp_t q8[$];
  logic [31:0] last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b, input int unsigned w);
    logic [63:0] mask;
    longint      ua, ub, sa, sb, minv;
    logic [63:0] t;
    mask = (64'd1 << w) - 64'd1;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = a[w-1] ? ua - (longint'(1) << w) : ua;
    sb   = b[w-1] ? ub - (longint'(1) << w) : ub;
    minv = -(longint'(1) << (w - 1));
    case (f)
      3'd0: begin t = ua * ub; return 32'(t & mask); end
      3'd1: begin t = sa * sb; return 32'((t >> w) & mask); end
      3'd2: begin t = sa * ub; return 32'((t >> w) & mask); end
      3'd3: begin t = ua * ub; return 32'((t >> w) & mask); end
      3'd4: begin
        if (ub == 0) return 32'(mask);
        if (sa == minv && sb == -1) return a;
        t = sa / sb; return 32'(t & mask);
      end
      3'd5: begin
        if (ub == 0) return 32'(mask);
        t = ua / ub; return 32'(t & mask);
      end
      3'd6: begin
        if (ub == 0) return a;
        if (sa == minv && sb == -1) return '0;
        t = sa % sb; return 32'(t & mask);
      end
      default: begin
        if (ub == 0) return a;
        t = ua % ub; return 32'(t & mask);
      end
    endcase
  endfunction

  function automatic logic [31:0] pick(input int unsigned w);
    logic [31:0] mask;
    mask = 32'((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return mask;
      2:       return 32'd1 << (w - 1);
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom & mask;
    endcase
  endfunction

  // Called at a negedge; holds start for one cycle and returns at the next negedge.
  task automatic issue(input bit w8, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r,
                       input bit expect_done, output int t0);
    int unsigned w;
    bit          special;
    exp_t        e;
    w = w8 ? 8 : 32;
    special = f[2] && ((b == 0) ||
              (!f[0] && a == (32'd1 << (w - 1)) && b == 32'((64'd1 << w) - 64'd1)));
    t0 = cyc;
    if (w8) begin
      bus8.start = 1'b1; bus8.funct3 = f; bus8.srca = a[7:0]; bus8.srcb = b[7:0];
    end else begin
      bus.start = 1'b1; bus.funct3 = f; bus.srca = a; bus.srcb = b;
    end
    if (expect_done) begin
      e.res = r;
      e.at  = t0 + (special ? 1 : int'(w) + 1);
      if (w8) q8.push_back(e);
      else begin q.push_back(e); last_exp = r; end
    end
    @(negedge clk);
    if (w8) begin
      bus8.start = 1'b0; bus8.funct3 = 3'($urandom); bus8.srca = 8'($urandom); bus8.srcb = 8'($urandom);
    end else begin
      bus.start = 1'b0; bus.funct3 = 3'($urandom); bus.srca = $urandom; bus.srcb = $urandom;
    end
  endtask

  task automatic wait_idle(input bit w8);
    for (int i = 0; i < 100; i++) begin
      if (!(w8 ? bus8.busy : bus.busy)) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL idle_timeout: got busy=1 after 100 cycles want busy=0 (w8=%0d)", w8);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done32: got done=1 want done=0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        check("result32", bus.result, e.res);
        check("latency32", 32'(cyc), 32'(e.at));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus8.done === 1'b1) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done8: got done=1 want done=0 (cycle %0d)", cyc);
      end else begin
        e = q8.pop_front();
        check("result8", {24'd0, bus8.result}, e.res);
        check("latency8", 32'(cyc), 32'(e.at));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  logic [2:0]  d_f[11]   = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a[11]   = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] d_b[11]   = '{32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] d_exp[11] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                             32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

  initial begin
    int          t0;
    logic [2:0]  f;
    logic [31:0] a, b, r;

    bus.start = 1'b0;  bus.kill = 1'b0;  bus.funct3 = '0;  bus.srca = '0;  bus.srcb = '0;
    bus8.start = 1'b0; bus8.kill = 1'b0; bus8.funct3 = '0; bus8.srca = '0; bus8.srcb = '0;

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_busy8", 32'(bus8.busy), 32'd0);
    check("reset_result8", {24'd0, bus8.result}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // MUL 7 * -3 with cycle-accurate busy/done profile
    issue(0, 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1, t0);
    for (int k = 1; k <= 33; k++) begin
      check("busy_run", 32'(bus.busy), 32'd1);
      check("done_run", 32'(bus.done), (k == 33) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check("busy_after", 32'(bus.busy), 32'd0);
    check("done_after", 32'(bus.done), 32'd0);

    for (int i = 0; i < 11; i++) begin
      issue(0, d_f[i], d_a[i], d_b[i], d_exp[i], 1, t0);
      wait_idle(0);
    end

    // Kill mid-RUN: no done, prior result retained
    issue(0, 3'd5, 32'd1000, 32'd3, 32'd333, 1, t0);
    wait_idle(0);
    issue(0, 3'd0, 32'd7, 32'd9, 32'd63, 0, t0);
    repeat (9) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_busy", 32'(bus.busy), 32'd0);
    check("kill_done", 32'(bus.done), 32'd0);
    check("kill_result", bus.result, 32'd333);
    repeat (40) @(negedge clk);
    check("kill_result_late", bus.result, 32'd333);

    // Start while busy is ignored
    issue(0, 3'd5, 32'd100, 32'd7, 32'd14, 1, t0);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.srca = 32'd3; bus.srcb = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(0);
    repeat (3) @(negedge clk);
    check("busy_start_result", bus.result, 32'd14);

    // Kill coinciding with DONE keeps the pulse and the result
    r = ref_op(3'd3, 32'h12345678, 32'h9ABCDEF0, 32);
    issue(0, 3'd3, 32'h12345678, 32'h9ABCDEF0, r, 1, t0);
    repeat (32) @(negedge clk);
    bus.kill = 1'b1;
    check("kill_done_pulse", 32'(bus.done), 32'd1);
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_done_busy", 32'(bus.busy), 32'd0);
    check("kill_done_result", bus.result, r);

    // Reset mid-RUN
    issue(0, 3'd0, 32'd5, 32'd5, 32'd25, 0, t0);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_exp = '0;
    @(negedge clk);
    issue(0, 3'd5, 32'd9, 32'd3, 32'd3, 1, t0);
    wait_idle(0);

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick(32);
      b = pick(32);
      issue(0, f, a, b, ref_op(f, a, b, 32), 1, t0);
      wait_idle(0);
    end

    issue(1, 3'd0, 32'h0F, 32'h0F, 32'hE1, 1, t0);
    wait_idle(1);
    for (int i = 0; i < 30; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick(8);
      b = pick(8);
      issue(1, f, a, b, ref_op(f, a, b, 8), 1, t0);
      wait_idle(1);
    end

    repeat (5) @(negedge clk);
    check("pending32", 32'(q.size()), 32'd0);
    check("pending8", 32'(q8.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
